fsb_ctl: RTL
============

FSB_CTL -- requirements
Module: fsb_ctl

Interface
REQ-001 Parameter RAM_WS, default 1: wait cycles inserted before acknowledging a non-posted RAM cycle.
REQ-002 Parameter ROM_WS, default 2: wait cycles inserted before acknowledging a ROM cycle.
REQ-003 Parameter TIMEOUT, default 255: wait-state cycles before a bus error; 8-bit range 1..255.
REQ-004 Port CLK, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port nRES, input, 1: reset, asynchronous, active-low.
REQ-006 Port BACT, input, 1: processor bus cycle active (address strobe asserted).
REQ-007 Port nWE, input, 1: low = write cycle.
REQ-008 Ports RAMCS, ROMCS, IOCS, IACS, IOPWCS, inputs, 1 each: device selects from the chip-select decoder.
REQ-009 Port RAMReady, input, 1: RAM arbiter grants the processor access this cycle.
REQ-010 Port IODONE, input, 1: single-cycle pulse from the IO bridge completing the outstanding IO request.
REQ-011 Port nDTACK, output, 1: data transfer acknowledge to the processor, active-low.
REQ-012 Port nVPA, output, 1: valid peripheral address (autovector for IACK), active-low.
REQ-013 Port nBERR, output, 1: bus error, active-low.
REQ-014 Port IORDREQ, output, 1: level request for a non-posted IO cycle; held until IODONE.
REQ-015 Port IOWRREQ, output, 1: write-buffer-occupied flag; held until IODONE.

Function
REQ-016 The state machine SHALL have states IDLE, RAMWAIT, ROMWAIT, IOFLUSH, IOWAIT, ACK, VPA, BERR, and HOLD.
REQ-017 In IDLE with BACT=1, selects SHALL be decoded by priority IACS > IOCS > ROMCS > RAMCS; BACT=1 with no select SHALL go to BERR.
REQ-018 IACS SHALL go to VPA; nVPA SHALL assert 1 cycle after entry and remain asserted until BACT=0.
REQ-019 IOCS&IOPWCS&!nWE with IOWRREQ=0 (or IODONE=1 in the same cycle) SHALL post the write: IOWRREQ=1 next cycle and ACK entered directly.
REQ-020 A posted write with the buffer full and no IODONE SHALL go to IOFLUSH, wait for IODONE, then post and enter ACK.
REQ-021 Any other IOCS cycle SHALL pass through IOFLUSH until IOWRREQ=0, then assert IORDREQ in IOWAIT until IODONE, then enter ACK; IORDREQ SHALL drop the cycle after IODONE.
REQ-022 ROMCS SHALL remain in ROMWAIT for ROM_WS cycles, then enter ACK.
REQ-023 RAMCS (non-posted) SHALL remain in RAMWAIT for at least RAM_WS cycles and until RAMReady=1, then enter ACK.
REQ-024 In ACK, nDTACK SHALL assert and the FSM SHALL move to HOLD; nDTACK SHALL stay asserted until BACT=0.
REQ-025 HOLD SHALL return to IDLE on BACT=0; nDTACK, nVPA and nBERR SHALL deassert in that same cycle.
REQ-026 An 8-bit counter SHALL clear on leaving IDLE and count in RAMWAIT, IOFLUSH and IOWAIT; reaching TIMEOUT SHALL go to BERR.
REQ-027 BERR SHALL assert nBERR until BACT=0, then return to IDLE; IORDREQ SHALL drop, while a posted write (IOWRREQ) SHALL remain pending.
REQ-028 BACT falling in any wait state SHALL abort to IDLE with no acknowledge; a pending posted write SHALL be retained.
REQ-029 IODONE while IOWRREQ=0 and IORDREQ=0 SHALL be ignored.
REQ-030 nDTACK, nVPA and nBERR SHALL be mutually exclusive in every cycle.

Reset
REQ-031 While nRES=0: state=IDLE, counter=0, nDTACK=1, nVPA=1, nBERR=1, IORDREQ=0, IOWRREQ=0 (buffer discarded), including mid-cycle.
REQ-032 After reset release, the first cycle SHALL be decoded only once BACT is seen low then high.

Structure
REQ-033 The state enumeration and the default RAM_WS/ROM_WS/TIMEOUT constants SHALL live in shared package fsb_pkg.
REQ-034 The wait/timeout counter SHALL be sub-module fsb_wscnt (clear, enable, terminal-count compare outputs).

Verification
REQ-035 ROM read, ROM_WS=2: BACT rises at cycle 0 -> nDTACK low at cycle 3, high the cycle BACT falls.
REQ-036 Two back-to-back video-RAM writes (IOCS=IOPWCS=1), IODONE withheld -> first: nDTACK at cycle 1 and IOWRREQ=1; second: held in IOFLUSH, IODONE at cycle 10 -> nDTACK at cycle 11, IOWRREQ stays 1.
REQ-037 VIA read with a posted write pending -> IORDREQ stays 0 until IODONE clears the buffer, then 1 until the second IODONE, then nDTACK.
REQ-038 IACK cycle (IACS=1) -> nVPA low 1 cycle after entry, nDTACK never asserts.
REQ-039 RAM read with RAMReady stuck 0, TIMEOUT=255 -> nBERR low at cycle 256, released when BACT falls.
REQ-040 nRES pulsed low during IOWAIT -> IORDREQ, IOWRREQ=0 and all strobes high immediately, asynchronously.

Source files
------------

// File: rtl/fsb_pkg.sv
// fsb_ctl shared types: bus-cycle FSM states and default timing constants.
// Imported by the controller and its wait-state counter.
package fsb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RAMWAIT,
    ST_ROMWAIT,
    ST_IOFLUSH,
    ST_IOWAIT,
    ST_ACK,
    ST_VPA,
    ST_BERR,
    ST_HOLD
  } fsb_state_t;

  localparam int unsigned RAM_WS_DEF  = 1;
  localparam int unsigned ROM_WS_DEF  = 2;
  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/fsb_wscnt.sv
// Wait-state / timeout counter for fsb_ctl.
// Cleared while idle; saturates at 255 so it never wraps.
module fsb_wscnt
  import fsb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] ws,
  output logic       ws_done,
  output logic       tmo
);

  logic [7:0] cnt;
  logic [8:0] nxt;

  // nxt is the number of wait cycles completed at the coming edge
  assign nxt     = {1'b0, cnt} + 9'd1;
  assign ws_done = nxt >= {1'b0, ws};
  assign tmo     = en && (nxt == 9'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != 8'hff) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fsb_ctl.sv
// 68k front-side-bus cycle controller: wait states, posted IO writes,
// IO read handshake, autovector and bus-error generation.
module fsb_ctl
  import fsb_pkg::*;
#(
  parameter int unsigned RAM_WS  = RAM_WS_DEF,
  parameter int unsigned ROM_WS  = ROM_WS_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic CLK,
  input  logic nRES,
  input  logic BACT,
  input  logic nWE,
  input  logic RAMCS,
  input  logic ROMCS,
  input  logic IOCS,
  input  logic IACS,
  input  logic IOPWCS,
  input  logic RAMReady,
  input  logic IODONE,
  output logic nDTACK,
  output logic nVPA,
  output logic nBERR,
  output logic IORDREQ,
  output logic IOWRREQ
);

  fsb_state_t state_q, state_d;

  logic wr_q;
  logic armed_q;
  logic pw_q;
  logic post;
  logic pw_in;
  logic ws_done;
  logic tmo;
  logic cnt_en;
  logic [7:0] ws_sel;

  logic sel_ia, sel_io, sel_rom, sel_ram, sel_none;

  // one-hot priority decode: IACS > IOCS > ROMCS > RAMCS
  assign sel_ia   = IACS;
  assign sel_io   = !IACS && IOCS;
  assign sel_rom  = !IACS && !IOCS && ROMCS;
  assign sel_ram  = !IACS && !IOCS && !ROMCS && RAMCS;
  assign sel_none = !IACS && !IOCS && !ROMCS && !RAMCS;

  assign pw_in = IOPWCS && !nWE;

  assign cnt_en = (state_q == ST_RAMWAIT) || (state_q == ST_ROMWAIT) ||
                  (state_q == ST_IOFLUSH) || (state_q == ST_IOWAIT);

  assign ws_sel = (state_q == ST_ROMWAIT) ? 8'(ROM_WS) : 8'(RAM_WS);

  fsb_wscnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wscnt (
    .clk     (CLK),
    .rst_n   (nRES),
    .clr     (state_q == ST_IDLE),
    .en      (cnt_en),
    .ws      (ws_sel),
    .ws_done (ws_done),
    .tmo     (tmo)
  );

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      armed_q <= 1'b0;
      pw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // a completion and a new post in one cycle leave the buffer full
      if (post) begin
        wr_q <= 1'b1;
      end else if (IODONE) begin
        wr_q <= 1'b0;
      end
      if (!BACT) begin
        armed_q <= 1'b1;
      end
      if (state_q == ST_IDLE) begin
        pw_q <= pw_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    post    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && BACT) begin
          unique case (1'b1)
            sel_ia:   state_d = ST_VPA;
            sel_io: begin
              if (pw_in && (!wr_q || IODONE)) begin
                state_d = ST_ACK;
                post    = 1'b1;
              end else begin
                state_d = ST_IOFLUSH;
              end
            end
            sel_rom:  state_d = ST_ROMWAIT;
            sel_ram:  state_d = ST_RAMWAIT;
            sel_none: state_d = ST_BERR;
          endcase
        end
      end
      ST_IOFLUSH: begin
        if (!BACT) begin
          state_d = ST_IDLE;
        end else if (pw_q && IODONE) begin
          state_d = ST_ACK;
          post    = 1'b1;
        end else if (!pw_q && (!wr_q || IODONE)) begin
          state_d = ST_IOWAIT;
        end else if (tmo) begin
          state_d = ST_BERR;
        end
      end
      ST_IOWAIT: begin
        if (!BACT) begin
          state_d = ST_IDLE;
        end else if (IODONE) begin
          state_d = ST_ACK;
        end else if (tmo) begin
          state_d = ST_BERR;
        end
      end
      ST_RAMWAIT: begin
        if (!BACT) begin
          state_d = ST_IDLE;
        end else if (ws_done && RAMReady) begin
          state_d = ST_ACK;
        end else if (tmo) begin
          state_d = ST_BERR;
        end
      end
      ST_ROMWAIT: begin
        if (!BACT) begin
          state_d = ST_IDLE;
        end else if (ws_done) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = BACT ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD, ST_VPA, ST_BERR: begin
        if (!BACT) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // strobes follow BACT so they release in the cycle the CPU ends the bus cycle
  assign nDTACK  = !(BACT && ((state_q == ST_ACK) || (state_q == ST_HOLD)));
  assign nVPA    = !(BACT && (state_q == ST_VPA));
  assign nBERR   = !(BACT && (state_q == ST_BERR));
  assign IORDREQ = (state_q == ST_IOWAIT);
  assign IOWRREQ = wr_q;

endmodule
